// File: rtl/riscv_pkg.sv
// Shared register map, STATUS bit positions and TX state encoding for the GPIO/UART block.
// No logic of its own; latency n/a.
// Backpressure n/a.
package riscv_pkg;

    localparam logic [4:0] OFF_LED    = 5'h00;
    localparam logic [4:0] OFF_BTN    = 5'h04;
    localparam logic [4:0] OFF_EDGE   = 5'h08;
    localparam logic [4:0] OFF_TXDATA = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: 2-flop synchroniser then a stability counter; emits a rise pulse.
// Latency: 2 sync cycles + DEB_CYC stable cycles before btn_deb follows the input.
// Backpressure: none, free-running.
module btn_debounce #(
    parameter int DEB_CYC = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_deb,
    output logic btn_rise
);
    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees; any agreement restarts the window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_deb  = deb_q;
    assign btn_rise = deb_d & ~deb_q;

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock circular FIFO with wrapping read/write pointers and occupancy count.
// Latency: pushed data visible at dout the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keep count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNW = $clog2(DEPTH + 1);

    logic [DEPTH*W-1:0] mem_q, mem_d;
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNW-1:0]     cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign full    = (cnt_q == CNW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[int'(rptr_q)*W +: W];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[int'(wptr_q)*W +: W] = din;
            wptr_d = (int'(wptr_q) == DEPTH - 1) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (int'(rptr_q) == DEPTH - 1) ? '0 : rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_gpio_uart.sv
// MMIO LED/button registers plus an 8N1 UART transmitter; UART_TX_FIFO_EN selects a FIFO_DEPTH queue over a holding register.
// Latency: writes land on the strobe edge, rdata one cycle after re, TX frame starts the cycle after a byte is queued.
// Backpressure: none on the bus; TXDATA writes to a full queue are dropped and flagged in STATUS.overflow.
module mmio_gpio_uart
    import riscv_pkg::*;
#(
    parameter int LED_W      = 4,
    parameter int BTN_W      = 4,
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 115200,
    parameter int DEB_CYC    = 100_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [4:0]       addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    input  logic [BTN_W-1:0] btn,
    output logic             uart_tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DIV);
`ifdef UART_TX_FIFO_EN
    localparam int QDEPTH = FIFO_DEPTH;
`else
    localparam int QDEPTH = 1;
`endif

    logic [4:0]       off;
    logic [31:0]      bmask, wmask, rd_val;
    logic             wr_led, wr_edge, wr_tx, wr_stat;

    logic [LED_W-1:0] led_q, led_d;
    logic [BTN_W-1:0] edge_q, edge_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [BTN_W-1:0] btn_deb, btn_rise;

    logic             q_push, q_pop, q_full, q_empty;
    logic [7:0]       q_dat;

    tx_state_e        state_q;
    logic [BCW-1:0]   baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             tx_q, busy_q;
    logic             baud_end;

    assign off     = {addr[4:2], 2'b00};
    assign bmask   = be_mask(be);
    assign wmask   = wdata & bmask;
    assign wr_led  = we && (off == OFF_LED);
    assign wr_edge = we && (off == OFF_EDGE);
    assign wr_tx   = we && (off == OFF_TXDATA);
    assign wr_stat = we && (off == OFF_STATUS);

    genvar gi;
    generate
        for (gi = 0; gi < BTN_W; gi++) begin : g_deb
            btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
                .clk      (clk),
                .rst_n    (rst_n),
                .btn_raw  (btn[gi]),
                .btn_deb  (btn_deb[gi]),
                .btn_rise (btn_rise[gi])
            );
        end
    endgenerate

    // A depth-1 FIFO is exactly the holding register: full whenever it holds a byte.
    assign q_push = wr_tx && be[0] && !q_full;

    sync_fifo #(.W(8), .DEPTH(QDEPTH)) u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .din   (wdata[7:0]),
        .dout  (q_dat),
        .full  (q_full),
        .empty (q_empty)
    );

    assign baud_end = (baud_q == BCW'(DIV - 1));
    assign q_pop    = !q_empty && ((state_q == TX_IDLE) || (state_q == TX_STOP && baud_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!q_empty) begin
                        state_q <= TX_START;
                        sh_q    <= q_dat;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (baud_end) begin
                        state_q <= TX_DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= {1'b0, sh_q[7:1]};
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= sh_q[0];
                            sh_q  <= {1'b0, sh_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (!q_empty) begin
                            state_q <= TX_START;
                            sh_q    <= q_dat;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        led_d   = led_q;
        edge_d  = edge_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        rd_val  = '0;
        if (wr_led) led_d = (led_q & ~bmask[LED_W-1:0]) | wmask[LED_W-1:0];
        if (wr_edge) edge_d = edge_q & ~wmask[BTN_W-1:0];
        // A new rising edge wins over a same-cycle clear.
        edge_d = edge_d | btn_rise;
        if (wr_stat && wmask[ST_OVF]) ovf_d = 1'b0;
        if (wr_tx && be[0] && q_full) ovf_d = 1'b1;
        case (off)
            OFF_LED:    rd_val[LED_W-1:0] = led_q;
            OFF_BTN:    rd_val[BTN_W-1:0] = btn_deb;
            OFF_EDGE:   rd_val[BTN_W-1:0] = edge_q;
            OFF_STATUS: begin
                rd_val[ST_BUSY]  = busy_q;
                rd_val[ST_FULL]  = q_full;
                rd_val[ST_EMPTY] = q_empty;
                rd_val[ST_OVF]   = ovf_q;
            end
            default:    rd_val = '0;
        endcase
        if (re) rdata_d = rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= '0;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            led_q   <= led_d;
            edge_q  <= edge_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign led     = led_q;
    assign rdata   = rdata_q;
    assign uart_tx = tx_q;

    logic unused_ok;
    assign unused_ok = ^{addr[1:0], bmask, wmask, (FIFO_DEPTH != 0)};

endmodule

// File: doc/mmio_gpio_uart.md
MMIO_GPIO_UART -- requirements
Module: mmio_gpio_uart

Interface
REQ-001 Parameter LED_W, default 4, number of LED output bits (1..32).
REQ-002 Parameter BTN_W, default 4, number of button input bits (1..32).
REQ-003 Parameter CLK_HZ, default 10_000_000, clk frequency in Hz.
REQ-004 Parameter BAUD, default 115200, UART bit rate; divisor DIV = CLK_HZ/BAUD (integer, truncated, DIV >= 2).
REQ-005 Parameter DEB_CYC, default 100_000, debounce stability window in clk cycles.
REQ-006 Parameter FIFO_DEPTH, default 4, TX FIFO entries, power of two (used only with UART_TX_FIFO_EN).
REQ-007 Ports, in this order:
  clk  in  1  system clock (single clock domain)
  rst_n  in  1  asynchronous, active-low reset
  we  in  1  register write strobe
  re  in  1  register read strobe
  addr  in  5  byte offset; bits [1:0] ignored
  be  in  4  write byte enables
  wdata  in  32  write data
  rdata  out  32  read data
  led  out  LED_W  LED register
  btn  in  BTN_W  raw asynchronous buttons
  uart_tx  out  1  UART serial output, idle high

Function
REQ-008 Register map (offset): 0x00 LED RW; 0x04 BTN RO; 0x08 BTN_EDGE W1C; 0x0C TXDATA WO; 0x10 STATUS (bit0 tx_busy, bit1 full, bit2 empty, bit3 overflow W1C).
REQ-009 Writes take effect on the clk edge with we=1, honouring be per byte; unmapped offsets ignored.
REQ-010 rdata is registered: valid the cycle after re=1, held until the next re; unmapped/write-only offsets read 0.
REQ-011 LED bits above LED_W read 0; led = LED register directly.
REQ-012 btn passes through a 2-flop synchroniser, then a per-bit counter; the debounced bit updates only after the raw value differs from it for DEB_CYC consecutive cycles; the counter clears on any bounce.
REQ-013 BTN_EDGE bit sets on a debounced 0->1 transition and stays set until written 1; a set and a clear in the same cycle leave the bit set.
REQ-014 Writing TXDATA with be[0]=1 enqueues wdata[7:0]; if full, the byte is dropped and overflow sets.
REQ-015 TX FSM states IDLE, START, DATA, STOP; IDLE->START when a byte is available (dequeued in the same cycle); each state bit lasts exactly DIV cycles; DATA sends 8 bits LSB first; STOP->START directly if another byte is available, else IDLE.
REQ-016 uart_tx is 1 in IDLE and STOP, 0 in START; tx_busy=1 in every state except IDLE.
REQ-017 A write to a non-full queue and a dequeue in the same cycle both occur; count is unchanged.

Reset
REQ-018 On rst_n=0, asynchronously: led=0, rdata=0, uart_tx=1, FSM=IDLE, queue empty, overflow=0, BTN_EDGE=0, debounced buttons=0, counters=0.
REQ-019 Reset asserted mid-frame aborts the frame; uart_tx returns to 1 at once; queued bytes are lost.

Configuration
REQ-020 Macro UART_TX_FIFO_EN defined: TX queue is a FIFO_DEPTH-entry circular FIFO with wrapping pointers; full when count==FIFO_DEPTH.
REQ-021 Macro UART_TX_FIFO_EN undefined: queue is a single holding register; full = holding register valid; FIFO_DEPTH ignored.

Structure
REQ-022 Register offsets, STATUS bit indices and the TX FSM state enum live in riscv_pkg.
REQ-023 The debouncer is a sub-module, btn_debounce, instantiated once per button bit.

Verification (CLK_HZ=10_000_000, BAUD=1_000_000, DIV=10, DEB_CYC=8)
REQ-024 Write 0x0000_000A to 0x00 with be=4'b0001 -> led=4'b1010 next cycle; read 0x00 -> rdata=0x0000_000A one cycle after re.
REQ-025 Write 0x55 to TXDATA -> uart_tx low 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then high 10 cycles; tx_busy high for 100 cycles.
REQ-026 FIFO build, depth 4: 6 back-to-back TXDATA writes while idle -> 5 bytes sent with no idle gap between frames, 6th dropped, STATUS bit3=1; write 0x8 to STATUS -> bit3=0.
REQ-027 btn[0] bounces 0/1 every 3 cycles for 30 cycles, then holds 1 -> debounced BTN[0] rises 2+8 cycles after the hold starts; BTN_EDGE[0]=1 until written 1.
REQ-028 rst_n pulled low 35 cycles into a frame -> uart_tx=1 in the same cycle, STATUS reads 0x4 after release.
